// File: rtl/tile_sdram_arbiter.sv
// tile_sdram_arbiter
//   Shares one toggle-handshake SDRAM read port among NUM_REQ tilemap-layer
//   fetchers. Grants round-robin, keeps one SDRAM request in flight, and
//   returns the addressed 32-bit half of the 64-bit SDRAM word.
//
// Ports
//   CLK_32M   system clock, rising edge
//   reset     synchronous, active-high
//   req       level request per requester
//   req_addr  flattened 32-bit-word addresses, requester i at [i*ADDR_W +: ADDR_W]
//   rdy       one-cycle completion pulse per requester
//   rdata     flattened read data, requester i at [i*32 +: 32], valid with rdy[i]
//   sdr_addr  SDRAM 16-bit-word address (bits [24:1] of the byte address)
//   sdr_req   toggles once per issued SDRAM request
//   sdr_rdy   request complete when sdr_rdy == sdr_req
//   sdr_data  SDRAM read data, valid when sdr_rdy == sdr_req
//
// Handshakes
//   Upstream: requester i holds req[i] and its address until rdy[i] pulses.
//   Downstream: a request is outstanding while sdr_req != sdr_rdy; it is
//   complete (and sdr_data valid) once the two levels are equal again.
//
// Build option
//   TILE_SDRAM_ARB_CACHE_EN: adds one 64-bit line buffer per requester so a
//   read that falls in the last fetched line is served without SDRAM traffic.
module tile_sdram_arbiter #(
  parameter int          NUM_REQ   = 2,
  parameter int          ADDR_W    = 20,
  parameter logic [23:0] BASE_ADDR = 24'h000000
) (
  input  logic                      CLK_32M,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        rdy,
  output logic [NUM_REQ*32-1:0]     rdata,
  output logic [23:0]               sdr_addr,
  output logic                      sdr_req,
  input  logic                      sdr_rdy,
  input  logic [63:0]               sdr_data
);

  localparam logic [1:0] ST_DRAIN = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
  localparam logic [1:0] LAST_REQ = 2'(NUM_REQ - 1);

  logic [1:0]            state_q, state_d;
  logic [1:0]            rr_ptr_q, rr_ptr_d;
  logic [1:0]            winner_q, winner_d;
  logic                  half_q, half_d;
  logic [23:0]           sdr_addr_q, sdr_addr_d;
  logic                  sdr_req_q, sdr_req_d;
  logic [NUM_REQ-1:0]    rdy_q, rdy_d;
  logic [NUM_REQ*32-1:0] rdata_q, rdata_d;

  logic                  sdr_match;
  logic [3:0]            req_ext;
  logic                  any_req;
  logic [1:0]            pick;
  logic [1:0]            idx;
  logic [ADDR_W-1:0]     pick_addr;
  logic                  hit;
  logic [31:0]           hit_word;

  assign sdr_match = (sdr_rdy == sdr_req_q);

  // Round-robin search: walk k = NUM_REQ..1 so the last hit written is the
  // requester closest after rr_ptr, i.e. the first active one in search order.
  always_comb begin
    req_ext = 4'b0000;
    req_ext[NUM_REQ-1:0] = req;
    any_req = 1'b0;
    pick    = 2'd0;
    idx     = 2'd0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = 2'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (req_ext[idx]) begin
        any_req = 1'b1;
        pick    = idx;
      end
    end
    pick_addr = req_addr[32'(pick)*ADDR_W +: ADDR_W];
  end

`ifdef TILE_SDRAM_ARB_CACHE_EN
  logic [63:0]       line_q [4];
  logic [ADDR_W-2:0] tag_q  [4];
  logic [3:0]        vld_q;
  logic [ADDR_W-2:0] ftag_q;

  always_comb begin
    hit      = vld_q[pick] && (tag_q[pick] == pick_addr[ADDR_W-1:1]);
    hit_word = pick_addr[0] ? line_q[pick][63:32] : line_q[pick][31:0];
  end

  // Line data and tags need no reset: nothing reads them while valid is clear.
  always_ff @(posedge CLK_32M) begin
    if (state_q == ST_IDLE && any_req) ftag_q <= pick_addr[ADDR_W-1:1];
    if (!reset && state_q == ST_WAIT && sdr_match) begin
      line_q[winner_q] <= sdr_data;
      tag_q[winner_q]  <= ftag_q;
    end
  end

  always_ff @(posedge CLK_32M) begin
    if (reset) begin
      vld_q <= 4'b0000;
    end else if (state_q == ST_WAIT && sdr_match) begin
      vld_q[winner_q] <= 1'b1;
    end
  end
`else
  always_comb begin
    hit      = 1'b0;
    hit_word = 32'h0;
  end
`endif

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    winner_d   = winner_q;
    half_d     = half_q;
    sdr_addr_d = sdr_addr_q;
    sdr_req_d  = sdr_req_q;
    rdy_d      = '0;
    rdata_d    = rdata_q;
    case (state_q)
      // Swallow any completion still owed from before reset.
      ST_DRAIN: if (sdr_match) state_d = ST_IDLE;
      ST_IDLE: begin
        if (any_req) begin
          if (hit) begin
            // Buffer hit: no SDRAM traffic and no change to fairness order.
            rdy_d                          = NUM_REQ'(4'b0001 << pick);
            rdata_d[32'(pick)*32 +: 32]    = hit_word;
            state_d                        = ST_DONE;
          end else begin
            winner_d   = pick;
            half_d     = pick_addr[0];
            sdr_addr_d = BASE_ADDR + 24'({pick_addr, 1'b0});
            sdr_req_d  = ~sdr_req_q;
            rr_ptr_d   = pick;
            state_d    = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (sdr_match) begin
          rdy_d                           = NUM_REQ'(4'b0001 << winner_q);
          rdata_d[32'(winner_q)*32 +: 32] = half_q ? sdr_data[63:32] : sdr_data[31:0];
          state_d                         = ST_DONE;
        end
      end
      // Bubble so the served requester can drop or change its request.
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_32M) begin
    if (reset) begin
      state_q    <= ST_DRAIN;
      rr_ptr_q   <= LAST_REQ;
      winner_q   <= 2'd0;
      half_q     <= 1'b0;
      sdr_addr_q <= 24'h0;
      rdy_q      <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      winner_q   <= winner_d;
      half_q     <= half_d;
      sdr_addr_q <= sdr_addr_d;
      rdy_q      <= rdy_d;
      rdata_q    <= rdata_d;
    end
  end

  // sdr_req is a toggle level shared with the SDRAM controller; forcing it in
  // reset would fake a request, so it only ever changes on a real grant.
  always_ff @(posedge CLK_32M) begin
    if (!reset) sdr_req_q <= sdr_req_d;
  end

  assign rdy      = rdy_q;
  assign rdata    = rdata_q;
  assign sdr_addr = sdr_addr_q;
  assign sdr_req  = sdr_req_q;

endmodule
